// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan sequencer.
package led_scan_pkg;

    // Sequencer control state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Pattern mode encodings as seen on the mode input.
    localparam logic [1:0] MODE_WALK   = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    // Select values at the two ends of the LED row.
    localparam logic [2:0] SEL_LOW  = 3'd0;
    localparam logic [2:0] SEL_HIGH = 3'd7;

    // One step along the LED row; the 3-bit result wraps modulo 8.
    function automatic logic [2:0] sel_step(input logic [2:0] cur, input logic down);
        logic [2:0] nxt;
        if (down) begin
            nxt = cur - 3'd1;
        end else begin
            nxt = cur + 3'd1;
        end
        return nxt;
    endfunction

    // End value of a sweep in the given direction.
    function automatic logic [2:0] sel_end(input logic down);
        return down ? SEL_LOW : SEL_HIGH;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts DIV clock cycles while enabled and flags the last one.
module led_tick_gen #(
    parameter int unsigned DIV = 25000000,
    parameter int unsigned CW  = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: cleared on request or while stopped, wraps after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan sequencer: drives demux select/data with walk, bounce, single-sweep
// and manual pass-through patterns, stepping once every DIV clock cycles.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int unsigned DIV = 25000000,
    parameter int unsigned CW  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       dir_down,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] man_sel,
    input  logic       man_data,
    output logic [2:0] sel,
    output logic       data,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic       dir_q,   dir_d;
    logic       data_q,  data_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic man_req;
    logic stop_req;
    logic start_req;
    logic tick;
    logic at_end;

    // Request decode in priority order: manual, then stop, then start.
    assign man_req   = (mode == MODE_MANUAL);
    assign stop_req  = !man_req && stop;
    assign start_req = !man_req && !stop && start;
    assign at_end    = (sel_q == sel_end(dir_q));

    // Any manual, stop or start request restarts the step interval from zero,
    // so the first step lands DIV cycles after an accepted start.
    led_tick_gen #(
        .DIV (DIV),
        .CW  (CW)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (man_req || stop || start),
        .en   (state_q == RUN),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; tick is only ever high in RUN.
    always_comb begin
        state_d = state_q;
        if (man_req || stop_req) begin
            state_d = IDLE;
        end else if (start_req) begin
            state_d = RUN;
        end else if (tick && (mode == MODE_SINGLE) && at_end) begin
            state_d = IDLE;
        end
    end

    // Next values of the registered outputs and the direction register.
    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        data_d = data_q;
        done_d = 1'b0;
        busy_d = (state_d == RUN);
        if (man_req) begin
            sel_d  = man_sel;
            data_d = man_data;
        end else if (stop_req) begin
            data_d = 1'b0;
        end else if (start_req) begin
            data_d = 1'b1;
            if (mode == MODE_BOUNCE) begin
                dir_d = 1'b0;
                sel_d = SEL_LOW;
            end else begin
                dir_d = dir_down;
                sel_d = dir_down ? SEL_HIGH : SEL_LOW;
            end
        end else if (tick) begin
            case (mode)
                MODE_WALK: begin
                    sel_d = sel_step(sel_q, dir_q);
                end
                MODE_BOUNCE: begin
                    // Reflect at either end: reverse and step away in one tick.
                    if (at_end) begin
                        dir_d = !dir_q;
                        sel_d = sel_step(sel_q, !dir_q);
                    end else begin
                        sel_d = sel_step(sel_q, dir_q);
                    end
                end
                MODE_SINGLE: begin
                    if (at_end) begin
                        data_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        sel_d = sel_step(sel_q, dir_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            dir_q  <= 1'b0;
            data_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            dir_q  <= dir_d;
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign sel  = sel_q;
    assign data = data_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl with DIV=4.
module tb_led_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       dir_down;
    logic       start;
    logic       stop;
    logic [2:0] man_sel;
    logic       man_data;
    logic [2:0] sel;
    logic       data;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model: position, direction, flags and cycles since start accept.
    int m_pos = 0;
    bit m_down = 1'b0;
    bit m_run = 1'b0;
    bit m_data = 1'b0;
    bit m_done = 1'b0;
    int m_el = 0;

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic       dd;
        logic       st;
        logic       sp;
        logic [2:0] ms;
        logic       md;
        logic [2:0] es;
        logic       ed;
        logic       eb;
        logic       edn;
    } vec_t;

    vec_t tbl[$];

    led_scan_ctrl #(
        .DIV (DIV),
        .CW  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .dir_down (dir_down),
        .start    (start),
        .stop     (stop),
        .man_sel  (man_sel),
        .man_data (man_data),
        .sel      (sel),
        .data     (data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

    task automatic setin(input logic r, input logic [1:0] m, input logic dd, input logic st,
                         input logic sp, input logic [2:0] ms, input logic md);
        rst = r; mode = m; dir_down = dd; start = st; stop = sp; man_sel = ms; man_data = md;
    endtask

    // Pattern rules applied once per clock edge, from the inputs at that edge.
    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_down = 1'b0; m_data = 1'b0; m_el = 0;
        end else if (mode == 2'b11) begin
            m_run = 1'b0; m_pos = int'(man_sel); m_data = man_data;
        end else if (stop) begin
            m_run = 1'b0; m_data = 1'b0;
        end else if (start) begin
            m_run = 1'b1; m_el = 0; m_data = 1'b1;
            if (mode == 2'b01) begin
                m_down = 1'b0; m_pos = 0;
            end else begin
                m_down = dir_down; m_pos = dir_down ? 7 : 0;
            end
        end else if (m_run) begin
            m_el++;
            if (m_el % DIV == 0) begin
                case (mode)
                    2'b00: m_pos = (m_pos + (m_down ? 7 : 1)) % 8;
                    2'b01: begin
                        if (!m_down && m_pos == 7) m_down = 1'b1;
                        else if (m_down && m_pos == 0) m_down = 1'b0;
                        m_pos = m_pos + (m_down ? -1 : 1);
                    end
                    default: begin
                        if (m_pos == (m_down ? 0 : 7)) begin
                            m_run = 1'b0; m_data = 1'b0; m_done = 1'b1;
                        end else begin
                            m_pos = m_pos + (m_down ? -1 : 1);
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [2:0] es, input logic ed,
                       input logic eb, input logic edn);
        checks++;
        if ({sel, data, busy, done} !== {es, ed, eb, edn}) begin
            errors++;
            $display("FAIL %s @%0t: got sel=%0d data=%b busy=%b done=%b, want sel=%0d data=%b busy=%b done=%b",
                     nm, $time, sel, data, busy, done, es, ed, eb, edn);
        end
    endtask

    // One clock edge checked against given constants.
    task automatic step_exp(input string nm, input logic [2:0] es, input logic ed,
                            input logic eb, input logic edn);
        @(posedge clk);
        model_step();
        #1;
        cmp(nm, es, ed, eb, edn);
    endtask

    // One clock edge checked against the reference model.
    task automatic step_chk(input string nm);
        @(posedge clk);
        model_step();
        #1;
        cmp(nm, 3'(m_pos), m_data, m_run, m_done);
    endtask

    task automatic add(input logic r, input logic [1:0] m, input logic dd, input logic st,
                       input logic sp, input logic [2:0] ms, input logic md,
                       input logic [2:0] es, input logic ed, input logic eb, input logic edn);
        vec_t v;
        v = '{r, m, dd, st, sp, ms, md, es, ed, eb, edn};
        tbl.push_back(v);
    endtask

    initial begin
        int k;
        logic [1:0] cur_mode;

        //   rst   mode  dd    st    sp    msel  md      sel   data  busy  done
        add(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0,   3'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0,   3'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0,   3'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0,   3'd1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1,   3'd5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0,   3'd6, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1,   3'd6, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0,   3'd7, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd7, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd7, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd7, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd6, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0,   3'd6, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0,   3'd6, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0,   3'd0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0,   3'd0, 1'b0, 1'b0, 1'b0);

        setin(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        foreach (tbl[i]) begin
            setin(tbl[i].r, tbl[i].m, tbl[i].dd, tbl[i].st, tbl[i].sp, tbl[i].ms, tbl[i].md);
            step_exp($sformatf("table[%0d]", i), tbl[i].es, tbl[i].ed, tbl[i].eb, tbl[i].edn);
        end

        // Walk up through the wrap 7 -> 0.
        setin(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("walk_up_start", 3'd0, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 36; i++) step_exp("walk_up", 3'((i / DIV) % 8), 1'b1, 1'b1, 1'b0);

        // Walk down through the wrap 0 -> 7.
        setin(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("walk_dn_start", 3'd7, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 36; i++) step_exp("walk_dn", 3'((71 - i / DIV) % 8), 1'b1, 1'b1, 1'b0);

        // Bounce with dir_down=1 at start (ignored): 0..7..0..1.
        setin(1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("bounce_start", 3'd0, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            k = (i / DIV) % 14;
            step_exp("bounce", 3'(k <= 7 ? k : 14 - k), 1'b1, 1'b1, 1'b0);
        end

        // Single sweep down, one done pulse, then silence.
        setin(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("single_start", 3'd7, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i < 8 * DIV; i++) step_exp("single_run", 3'(7 - i / DIV), 1'b1, 1'b1, 1'b0);
        step_exp("single_done", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step_exp("single_after", 3'd0, 1'b0, 1'b0, 1'b0);

        // Stop in walk at sel=3, then start+stop together.
        setin(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("stop_start", 3'd0, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 3 * DIV; i++) step_exp("stop_run", 3'(i / DIV), 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        step_exp("stop_hit", 3'd3, 1'b0, 1'b0, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step_exp("stop_beats_start", 3'd3, 1'b0, 1'b0, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) step_exp("stop_idle", 3'd3, 1'b0, 1'b0, 1'b0);

        // Manual override during RUN at sel=2.
        setin(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step_exp("man_start", 3'd0, 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 1; i <= 2 * DIV; i++) step_exp("man_run", 3'(i / DIV), 1'b1, 1'b1, 1'b0);
        setin(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
        step_exp("man_enter", 3'd5, 1'b1, 1'b0, 1'b0);
        setin(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
        step_exp("man_sel6", 3'd6, 1'b1, 1'b0, 1'b0);
        setin(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) step_exp("man_exit_idle", 3'd6, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        setin(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step_chk("rand_reset");
        cur_mode = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_mode = 2'($urandom_range(0, 3));
            setin($urandom_range(0, 299) == 0, cur_mode, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 89) == 0,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            step_chk("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
